// File: rtl/aes_pkg.sv
// Shared AES types, S-box tables and FSM encoding.
// SBOX is only referenced when INV_SUB_BYTES_FWD_EN is defined.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  localparam int AES_STATE_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } isb_state_t;

  localparam aes_byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  localparam aes_byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/inv_sbox.sv
// Single-byte inverse S-box lookup (combinational).
// With INV_SUB_BYTES_FWD_EN, fwd=1 selects the forward S-box.
module inv_sbox
  import aes_pkg::*;
(
`ifdef INV_SUB_BYTES_FWD_EN
  input  logic      fwd,
`endif
  input  aes_byte_t in_byte,
  output aes_byte_t out_byte
);

  // table lookup
  always_comb begin
`ifdef INV_SUB_BYTES_FWD_EN
    out_byte = fwd ? SBOX[in_byte] : INV_SBOX[in_byte];
`else
    out_byte = INV_SBOX[in_byte];
`endif
  end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential InvSubBytes: BYTES_PER_CYCLE bytes per busy cycle.
// INV_SUB_BYTES_FWD_EN adds a mode port (1 = forward S-box).
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
`ifdef INV_SUB_BYTES_FWD_EN
  input  logic       mode,
`endif
  input  aes_state_t state_in,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t state_out,
  output logic       busy
);

  localparam int B  = BYTES_PER_CYCLE;
  localparam int N  = AES_STATE_BYTES / B;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int W  = 8 * B;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (B != 1 && B != 2 && B != 4 &&
      B != 8 && B != 16) begin : g_bad_b
    $error("BYTES_PER_CYCLE must be 1/2/4/8/16");
  end

  isb_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q;
  aes_state_t      work_q, work_d;
  logic [W-1:0]    chunk, sub;
`ifdef INV_SUB_BYTES_FWD_EN
  logic            mode_q;
`endif

  // pick the chunk addressed by the counter, splice back its substitution
  always_comb begin
    chunk  = '0;
    work_d = work_q;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CW'(k)) begin
        chunk = work_q[127-W*k -: W];
        work_d[127-W*k -: W] = sub;
      end
    end
  end

  for (genvar j = 0; j < B; j++) begin : g_sbox
    inv_sbox u_sbox (
`ifdef INV_SUB_BYTES_FWD_EN
      .fwd      (mode_q),
`endif
      .in_byte  (chunk[8*(B-1-j) +: 8]),
      .out_byte (sub[8*(B-1-j) +: 8])
    );
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid)       state_d = BUSY;
      BUSY: if (cnt_q == LAST)  state_d = DONE;
      DONE: if (out_ready)      state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // working register, chunk counter and stored mode
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      cnt_q  <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
      mode_q <= 1'b0;
`endif
    end else if (state_q == IDLE && in_valid) begin
      work_q <= state_in;
      cnt_q  <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
      mode_q <= mode;
`endif
    end else if (state_q == BUSY) begin
      work_q <= work_d;
      cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign state_out = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Scoreboard bench: B=16, B=4 and B=1 instances share stimulus.
// Per-instance monitors check data, latency and busy length.
module tb_inv_sub_bytes_seq;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  aes_state_t state_in;
`ifdef INV_SUB_BYTES_FWD_EN
  logic       mode = 1'b0;
`endif
  logic [2:0] in_ready_w, out_valid_w, busy_w;
  aes_state_t so_w [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  aes_state_t exp_q [3][$];

  localparam aes_state_t V_FIPS_I = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam aes_state_t V_FIPS_O = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam aes_state_t V_63 = {16{8'h63}};
  localparam aes_state_t V_00 = {16{8'h00}};
  localparam aes_state_t V_52 = {16{8'h52}};
  localparam aes_state_t V_16 = {16{8'h16}};
  localparam aes_state_t V_FF = {16{8'hff}};

  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) u_b16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
`ifdef INV_SUB_BYTES_FWD_EN
    .mode(mode),
`endif
    .state_in(state_in), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .state_out(so_w[0]), .busy(busy_w[0]));

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) u_b4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
`ifdef INV_SUB_BYTES_FWD_EN
    .mode(mode),
`endif
    .state_in(state_in), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .state_out(so_w[1]), .busy(busy_w[1]));

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) u_b1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
`ifdef INV_SUB_BYTES_FWD_EN
    .mode(mode),
`endif
    .state_in(state_in), .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .state_out(so_w[2]), .busy(busy_w[2]));

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // per-instance monitors
  for (genvar g = 0; g < 3; g++) begin : g_mon
    localparam int NN = (g == 0) ? 16 : (g == 1) ? 4 : 1;
    localparam int LAT = 16 / NN;
    initial begin
      int acc, bcnt;
      logic act, pv;
      aes_state_t cur;
      acc = 0; bcnt = 0; act = 1'b0; pv = 1'b0; cur = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          act = 1'b0; bcnt = 0; pv = 1'b0;
        end else begin
          if (busy_w[g]) bcnt++;
          if (in_valid && in_ready_w[g]) begin
            act = 1'b1; acc = cyc + 1; bcnt = 0;
          end
          if (out_valid_w[g] && !pv) begin
            if (exp_q[g].size() == 0 || !act) begin
              total++; bad++;
              $display("FAIL unexpected_out inst=%0d got=%h", g, so_w[g]);
            end else begin
              cur = exp_q[g].pop_front();
              chk($sformatf("data%0d", g), so_w[g], cur);
              chk($sformatf("latency%0d", g), 128'(cyc - acc), 128'(LAT));
              chk($sformatf("busy_len%0d", g), 128'(bcnt), 128'(LAT));
              act = 1'b0;
            end
          end else if (out_valid_w[g] && pv) begin
            chk($sformatf("hold%0d", g), so_w[g], cur);
          end
          pv = out_valid_w[g];
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (in_ready_w !== 3'b111 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL idle_timeout got=%b want=111", in_ready_w);
    end
  endtask

  task automatic send(input aes_state_t d, input aes_state_t e);
    wait_idle();
    state_in = d;
    in_valid = 1'b1;
    for (int g = 0; g < 3; g++) exp_q[g].push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    state_in = ~d;
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_in_ready"}, 128'(in_ready_w), 128'(3'b111));
    chk({nm, "_out_valid"}, 128'(out_valid_w), 128'(3'b000));
    chk({nm, "_busy"}, 128'(busy_w), 128'(3'b000));
    for (int g = 0; g < 3; g++)
      chk({nm, "_state_out"}, so_w[g], 128'h0);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; state_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    send(V_FIPS_I, V_FIPS_O);
    send(V_63, V_00);
    send(V_00, V_52);
    send(V_16, V_FF);

    // in_valid pulse while busy must be ignored
    send(V_63, V_00);
    @(posedge clk); #1;
    in_valid = 1'b1; state_in = V_FIPS_I;
    @(posedge clk); #1;
    in_valid = 1'b0;

    // backpressure in DONE
    wait_idle();
    out_ready = 1'b0;
    send(V_FIPS_I, V_FIPS_O);
    n = 0;
    while (out_valid_w !== 3'b111 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_all_done", 128'(out_valid_w), 128'(3'b111));
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 128'(in_ready_w), 128'(3'b000));
      chk("bp_out_valid", 128'(out_valid_w), 128'(3'b111));
      chk("bp_state_out", so_w[1], V_FIPS_O);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_in_ready", 128'(in_ready_w), 128'(3'b111));
    chk("bp_rel_out_valid", 128'(out_valid_w), 128'(3'b000));

    // reset in second busy cycle of the B=4 instance
    send(V_FIPS_I, V_FIPS_O);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle("midrst");
    rst = 1'b0;
    for (int g = 0; g < 3; g++) exp_q[g].delete();
    send(V_16, V_FF);

`ifdef INV_SUB_BYTES_FWD_EN
    mode = 1'b1;
    send(V_FIPS_O, V_FIPS_I);
    mode = 1'b0;
    send(V_FIPS_I, V_FIPS_O);
`endif

    // drain
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0 ||
            in_ready_w !== 3'b111) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_pending", 128'(exp_q[0].size() + exp_q[1].size() +
        exp_q[2].size()), 128'h0);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
